fetch_cycle: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline and the producer side of the IF/ID boundary. It keeps the PC and fetches instructions from a variable-latency instruction memory using a request/response handshake. It drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D) that the decode stage consumes. It handles decode stalls with a one-entry holding buffer, branch redirects from execute, and decode flushes by inserting a NOP bubble.

---
 rtl/fetch_cycle_pkg.sv | 16 +
 rtl/fetch_cycle_if_id_reg.sv | 53 +++++
 rtl/fetch_cycle.sv | 113 +++++++++++
 tb/tb_fetch_cycle.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_cycle_pkg.sv
// Shared pipeline definitions: datapath width, the NOP encoding and the fetch FSM states.
package fetch_cycle_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_cycle_if_id_reg.sv
// IF/ID pipeline register; flush beats stall, stall beats load, and idle cycles insert a NOP.
module fetch_cycle_if_id_reg
  import fetch_cycle_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_plus4_q
);

  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;

  always_comb begin
    instr_d    = NOP;
    pc_d       = '0;
    pc_plus4_d = '0;
    if (flush) begin
      instr_d    = NOP;
      pc_d       = '0;
      pc_plus4_d = '0;
    end else if (stall) begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
    end else if (load) begin
      instr_d    = instr;
      pc_d       = pc;
      pc_plus4_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch: PC, single-outstanding imem request FSM, one-entry stall buffer,
// redirect handling and the IF/ID register feeding decode.
module fetch_cycle
  import fetch_cycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            buf_v_q, buf_v_d;

  logic [XLEN-1:0] pc_plus4;
  logic            consume_rsp;
  logic            release_buf;
  logic [XLEN-1:0] load_instr;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    buf_v_d     = buf_v_q;
    consume_rsp = 1'b0;
    release_buf = 1'b0;
    if (PCSrcE) begin
      pc_d    = PCTargetE;
      buf_v_d = 1'b0;
      unique case (state_q)
        WAIT:    state_d = imem_rvalid ? REQ : KILL;
        // A stale response landing together with the redirect is the drain itself.
        KILL:    state_d = imem_rvalid ? REQ : KILL;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (!StallD) begin
              consume_rsp = 1'b1;
              pc_d        = pc_plus4;
            end else begin
              buf_d   = imem_rdata;
              buf_v_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
        KILL: if (imem_rvalid) state_d = REQ;
        HOLD: begin
          if (!StallD) begin
            release_buf = 1'b1;
            pc_d        = pc_plus4;
            buf_v_d     = 1'b0;
            state_d     = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // Consuming a response re-issues at once for the next sequential PC.
  assign imem_req   = rst & (((state_q == REQ) & ~PCSrcE) | consume_rsp);
  assign imem_addr  = consume_rsp ? pc_plus4 : pc_q;
  assign load_instr = release_buf ? buf_q : imem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      buf_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
    end
  end

  fetch_cycle_if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (FlushD),
    .stall      (StallD),
    .load       (consume_rsp | release_buf),
    .instr      (load_instr),
    .pc         (pc_q),
    .pc_plus4   (pc_plus4),
    .instr_q    (InstrD),
    .pc_q       (PCD),
    .pc_plus4_q (PCPlus4D)
  );

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed cycle-by-cycle bench for fetch_cycle with a variable-latency instruction memory model.
module tb_fetch_cycle;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  int n_vec  = 0;
  int n_miss = 0;
  int lat    = 1;

  fetch_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h1234_5678;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] instr, input logic [31:0] pcd, input logic [31:0] p4);
    @(negedge clk);
    check_vec({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) check_vec({tag, ".addr"}, imem_addr, addr);
    check_vec({tag, ".instr"}, InstrD, instr);
    check_vec({tag, ".pcd"}, PCD, pcd);
    check_vec({tag, ".pc4"}, PCPlus4D, p4);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Memory model: one response per accepted request, lat cycles later.
  initial begin : imem_model
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] paddr;
    int          cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    paddr       = '0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      fire  = imem_req;
      faddr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (fire) begin
          cnt   = lat;
          paddr = faddr;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    repeat (2) @(posedge clk);
    exp_cyc("rst_hold", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);

    // back-to-back fetch with 1-cycle memory
    adv(); rst = 1'b1;
    exp_cyc("c0", 1'b1, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("c1", 1'b1, 32'h4, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("c2", 1'b1, 32'h8, 32'h00A0_0093, 32'h0, 32'h4);

    // decode stall while the word for 0x8 arrives
    adv(); StallD = 1'b1;
    exp_cyc("stl0", 1'b0, 32'h0, 32'h0010_0113, 32'h4, 32'h8);
    adv(); exp_cyc("stl1", 1'b0, 32'h0, 32'h0010_0113, 32'h4, 32'h8);
    adv(); exp_cyc("stl2", 1'b0, 32'h0, 32'h0010_0113, 32'h4, 32'h8);
    adv(); StallD = 1'b0;
    exp_cyc("stl_rel", 1'b0, 32'h0, 32'h0010_0113, 32'h4, 32'h8);
    adv(); lat = 3;
    exp_cyc("hold_out", 1'b1, 32'hC, 32'h1234_5678, 32'h8, 32'hC);

    // 3-cycle memory, redirect while the request to 0x10 is in flight
    adv(); exp_cyc("l3_w0", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("l3_w1", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("l3_rsp", 1'b1, 32'h10, NOP_W, 32'h0, 32'h0);
    adv(); PCSrcE = 1'b1; PCTargetE = 32'h100;
    exp_cyc("redir", 1'b0, 32'h0, 32'hA5A5_000C, 32'hC, 32'h10);
    adv(); PCSrcE = 1'b0;
    exp_cyc("kill0", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("kill_drain", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("tgt_req", 1'b1, 32'h100, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("tgt_w0", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("tgt_w1", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("tgt_rsp", 1'b1, 32'h104, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("tgt_out", 1'b0, 32'h0, 32'hA5A5_0100, 32'h100, 32'h104);
    adv(); exp_cyc("tgt_gap", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);

    // redirect + flush on the cycle the response lands
    adv(); PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200; lat = 1;
    exp_cyc("rf_cyc", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); PCSrcE = 1'b0; FlushD = 1'b0;
    exp_cyc("rf_next", 1'b1, 32'h200, NOP_W, 32'h0, 32'h0);

    // flush during stall; buffered word survives
    adv(); StallD = 1'b1; FlushD = 1'b1;
    exp_cyc("fs_cyc", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); StallD = 1'b0; FlushD = 1'b0;
    exp_cyc("fs_nop", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("fs_buf", 1'b1, 32'h204, 32'hA5A5_0200, 32'h200, 32'h204);

    // redirect to the top of the address space, PC wraps
    adv(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    exp_cyc("wr_redir", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); PCSrcE = 1'b0;
    exp_cyc("wr_req", 1'b1, 32'hFFFF_FFFC, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("wr_next", 1'b1, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("wr_out", 1'b1, 32'h4, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0);

    // reset mid-stream
    adv(); rst = 1'b0;
    exp_cyc("mrst0", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("mrst1", 1'b0, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); rst = 1'b1;
    exp_cyc("mrst_rel", 1'b1, 32'h0, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("mrst_b2b", 1'b1, 32'h4, NOP_W, 32'h0, 32'h0);
    adv(); exp_cyc("mrst_out", 1'b1, 32'h8, 32'h00A0_0093, 32'h0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
